// File: rtl/inv_array_freq_meter.sv
// Frequency meter for the analog inverter / ring-oscillator array.
// Enables the selected channels, lets them settle, then counts the
// synchronized rising edges of each oscillator over a gate window of
// wb_clk_i cycles and publishes saturating per-channel results.
module inv_array_freq_meter #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SETTLE      = 8,
  parameter int SYNC_STAGES = 2,
  localparam int RD_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             wb_clk_i,
  input  logic             resetb,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic [NCH-1:0]   ch_en_i,
  input  logic [NCH-1:0]   osc_i,
  output logic [NCH-1:0]   osc_en_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic [RD_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [NCH-1:0]   ovf_o
);

  localparam logic [GATE_W-1:0] TMR_ONE     = GATE_W'(1);
  localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   timer_q, timer_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q [NCH];
  logic [CNT_W-1:0]    cnt_d [NCH];
  logic [CNT_W-1:0]    res_q [NCH];
  logic [CNT_W-1:0]    res_d [NCH];
  logic [NCH-1:0]      ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [NCH-1:0]      prev_q;
  logic [NCH-1:0]      rise;
  logic [CNT_W-1:0]    rd_q, rd_d;

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: abort beats timer expiry; start is only heard in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_SETTLE;
      S_SETTLE: begin
        if (abort_i)             state_d = S_IDLE;
        else if (timer_q == '0)  state_d = (gate_q == '0) ? S_DONE : S_COUNT;
      end
      S_COUNT: begin
        if (abort_i)             state_d = S_IDLE;
        else if (timer_q == '0)  state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: oscillators only run while settling or counting
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_DONE);
    osc_en_o = ((state_q == S_SETTLE) || (state_q == S_COUNT)) ? mask_q : '0;
  end

  // Rising-edge detect on the last synchronizer stage against its previous value
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      rise[i] = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
    end
  end

  // Datapath next state: capture config, run the window timer, count, publish
  always_comb begin
    gate_d  = gate_q;
    mask_d  = mask_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      res_d[i] = res_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          gate_d  = gate_len_i;
          mask_d  = ch_en_i;
          timer_d = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
        if (timer_q != '0) timer_d = timer_q - TMR_ONE;
        else               timer_d = gate_q - TMR_ONE;
      end
      S_COUNT: begin
        if (timer_q != '0) timer_d = timer_q - TMR_ONE;
        for (int i = 0; i < NCH; i++) begin
          if (mask_q[i] && rise[i] && !(&cnt_q[i])) cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      S_DONE: begin
        for (int i = 0; i < NCH; i++) begin
          res_d[i] = cnt_q[i];
          ovf_d[i] = mask_q[i] & (&cnt_q[i]);
        end
      end
      default: ;
    endcase
  end

  // Readout mux; out-of-range selects read as zero
  always_comb begin
    rd_d = '0;
    if (int'(rd_sel_i) < NCH) rd_d = res_q[rd_sel_i];
  end

  // Datapath registers
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      gate_q  <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      ovf_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      gate_q  <= gate_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

  // Synchronizers for the asynchronous oscillator inputs; they run continuously
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      prev_q <= '0;
      for (int i = 0; i < NCH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], osc_i[i]};
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  assign rd_data_o = rd_q;
  assign ovf_o     = ovf_q;

endmodule
